// File: rtl/vec_mult_pkg.sv
// rtl/vec_mult_pkg.sv - shared types, widths and helpers for the vector-multiply sequencer
// Contents: sequencer state enum, default operand widths, result width, clog2 helper.
package vec_mult_pkg;

    localparam int W_U_DEF = 32;
    localparam int W_V_DEF = 32;
    localparam int RES_W   = W_U_DEF + W_V_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Ceiling log2 usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_mult_sequencer_if.sv
// rtl/vec_mult_sequencer_if.sv - input stream, vectorMult bus and output stream bundle
// master: sequencer side (accepts in_*, drives mul_u/mul_v, presents out_*).
// slave : environment side (upstream source, vectorMult, downstream sink).
interface vec_mult_sequencer_if #(
    parameter int DIM = 10,
    parameter int W_u = 32,
    parameter int W_v = 32
);
    localparam int RW = W_u + W_v;

    logic                 in_valid;
    logic                 in_ready;
    logic [DIM*W_u-1:0]   in_u;
    logic [DIM*W_v-1:0]   in_v;

    logic [DIM*W_u-1:0]   mul_u;
    logic [DIM*W_v-1:0]   mul_v;
    logic [DIM*RW-1:0]    mul_result;

    logic                 out_valid;
    logic                 out_ready;
    logic [DIM*RW-1:0]    out_result;
    logic                 out_last;

    modport master (
        input  in_valid, in_u, in_v, mul_result, out_ready,
        output in_ready, mul_u, mul_v, out_valid, out_result, out_last
    );

    modport slave (
        output in_valid, in_u, in_v, mul_result, out_ready,
        input  in_ready, mul_u, mul_v, out_valid, out_result, out_last
    );

endinterface

// File: rtl/vm_result_fifo.sv
// rtl/vm_result_fifo.sv - result buffer FIFO (power-of-two depth, first-word fall-through)
// Ports: Clock, Reset_n (async active-low), push/push_data, pop/pop_data (head),
//        count (occupancy), full, empty.
module vm_result_fifo
    import vec_mult_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A full buffer may still take a push when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/vec_mult_sequencer.sv
// rtl/vec_mult_sequencer.sv - job controller streaming vector pairs through one vectorMult
// Ports: Clock, Reset_n (async active-low); start/num_pairs launch a job; busy while
//        a job runs; done pulses after the last result leaves; bus carries the input
//        stream, the registered vectorMult operands/result and the output stream.
module vec_mult_sequencer
    import vec_mult_pkg::*;
#(
    parameter int DIM       = 10,
    parameter int W_u       = W_U_DEF,
    parameter int W_v       = W_V_DEF,
    parameter int MULT_LAT  = 2,
    parameter int CNT_W     = 16,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_pairs,
    output logic                 busy,
    output logic                 done,
    vec_mult_sequencer_if.master bus
);

    localparam int RW     = W_u + W_v;
    localparam int CRED_W = clog2(BUF_DEPTH) + 1;
    // One stage for the mul_u/mul_v register plus the vectorMult latency.
    localparam int PIPE_N = MULT_LAT + 1;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [CNT_W-1:0]  issue_left;
    logic [CNT_W-1:0]  issue_left_nxt;
    logic [CNT_W-1:0]  drain_left;
    logic [CNT_W-1:0]  drain_left_nxt;
    logic              done_nxt;
    logic [PIPE_N-1:0] vpipe;
    logic [CRED_W-1:0] inflight;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] buf_count;
    logic              buf_full;
    logic              buf_empty;
    logic              push;
    logic              pop;
    logic              in_fire;

    vm_result_fifo #(
        .WIDTH (DIM*RW),
        .DEPTH (BUF_DEPTH)
    ) u_result_fifo (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .push      (push),
        .push_data (bus.mul_result),
        .pop       (pop),
        .pop_data  (bus.out_result),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // The pipe tail marks the cycle in which mul_result belongs to an issued pair.
    assign push          = vpipe[PIPE_N-1];
    assign bus.out_valid = ~buf_empty;
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_last  = bus.out_valid & (drain_left == CNT_W'(1));
    assign busy          = (state != IDLE);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_N; i++) begin
            inflight = inflight + CRED_W'(vpipe[i]);
        end
    end

    // Every pair is either in the pipe or in the buffer, so issuing only while
    // their sum is below the depth makes overflow impossible. A pop in the same
    // cycle frees its slot at this edge, which sustains one pair per cycle.
    assign credits     = CRED_W'(BUF_DEPTH) - buf_count - inflight + CRED_W'(pop);
    assign bus.in_ready = (state == ISSUE) & (issue_left != '0) & (credits != '0);
    assign in_fire     = bus.in_valid & bus.in_ready;

    always_comb begin
        state_nxt      = state;
        issue_left_nxt = issue_left;
        drain_left_nxt = drain_left;
        done_nxt       = 1'b0;

        if (pop && (drain_left != '0)) begin
            drain_left_nxt = drain_left - CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    if (num_pairs == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt      = ISSUE;
                        issue_left_nxt = num_pairs;
                        drain_left_nxt = num_pairs;
                    end
                end
            end
            ISSUE: begin
                if (in_fire) begin
                    issue_left_nxt = issue_left - CNT_W'(1);
                    if (issue_left == CNT_W'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (drain_left == CNT_W'(1))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            issue_left <= '0;
            drain_left <= '0;
            vpipe      <= '0;
            done       <= 1'b0;
            bus.mul_u  <= '0;
            bus.mul_v  <= '0;
        end else begin
            state      <= state_nxt;
            issue_left <= issue_left_nxt;
            drain_left <= drain_left_nxt;
            vpipe      <= {vpipe[PIPE_N-2:0], in_fire};
            done       <= done_nxt;
            if (in_fire) begin
                bus.mul_u <= bus.in_u;
                bus.mul_v <= bus.in_v;
            end
        end
    end

    always @(posedge Clock) begin
        if (Reset_n) begin
            assert (buf_count <= CRED_W'(BUF_DEPTH));
            assert (!(push && buf_full && !pop));
        end
    end

endmodule

// File: tb/tb_vec_mult_sequencer.sv
// tb/tb_vec_mult_sequencer.sv - scoreboard bench for vec_mult_sequencer with a vectorMult model
module tb_vec_mult_sequencer;
    import vec_mult_pkg::*;

    localparam int DIM       = 2;
    localparam int W         = 32;
    localparam int MULT_LAT  = 2;
    localparam int CNT_W     = 16;
    localparam int BUF_DEPTH = 4;
    localparam int VW        = DIM * W;
    localparam int RVW       = DIM * RES_W;

    typedef struct packed {
        logic [RVW-1:0] res;
        logic           last;
    } exp_t;

    logic             Clock = 1'b0;
    logic             Reset_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_pairs = '0;
    logic             busy;
    logic             done;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    int   n_done = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   last_pop_cyc = 0;
    int   done_cyc = 0;
    int   rdy_mode = 0;
    exp_t expq[$];
    exp_t mon_e;

    vec_mult_sequencer_if #(.DIM(DIM), .W_u(W), .W_v(W)) bus ();

    vec_mult_sequencer #(
        .DIM(DIM), .W_u(W), .W_v(W), .MULT_LAT(MULT_LAT),
        .CNT_W(CNT_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .start     (start),
        .num_pairs (num_pairs),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Reference: element-wise product of the operands, computed with plain arithmetic.
    function automatic logic [RVW-1:0] ref_mult(input logic [VW-1:0] u, input logic [VW-1:0] v);
        logic [RVW-1:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) begin
            r[i*RES_W +: RES_W] = {32'b0, u[i*W +: W]} * {32'b0, v[i*W +: W]};
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] x;
        for (int i = 0; i < DIM; i++) begin
            x[i*W +: W] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        end
        return x;
    endfunction

    // External vectorMult: fixed MULT_LAT latency, no stall.
    logic [RVW-1:0] mr [MULT_LAT];
    always @(posedge Clock) begin
        mr[0] <= ref_mult(bus.mul_u, bus.mul_v);
        for (int k = 1; k < MULT_LAT; k++) mr[k] <= mr[k-1];
    end
    assign bus.mul_result = mr[MULT_LAT-1];

    // Downstream readiness: 0 = stall, 1 = always ready, 2 = random.
    always @(posedge Clock) begin
        #2;
        case (rdy_mode)
            1:       bus.out_ready = 1'b1;
            2:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [RVW-1:0] act, input logic [RVW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a result.
    always @(negedge Clock) begin
        if (Reset_n && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h, expected no result", bus.out_result);
            end else begin
                mon_e = expq.pop_front();
                check("out_result", bus.out_result, mon_e.res);
                check1("out_last", bus.out_last, mon_e.last);
            end
            n_pop++;
            if (bus.out_last) last_pop_cyc = cyc;
        end
        if (Reset_n && done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        num_pairs = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [VW-1:0] u, input logic [VW-1:0] v,
                             input logic [RVW-1:0] exp_res, input logic last,
                             input int limit, output bit ok);
        exp_t e;
        bus.in_u = u;
        bus.in_v = v;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge Clock);
            if (bus.in_ready) begin
                acc_cyc = cyc;
                e.res = exp_res;
                e.last = last;
                expq.push_back(e);
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge Clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check1("done_pulse", seen, 1'b1);
        if (seen) check1("busy_at_done", busy, 1'b0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] u, v;
        logic [VW-1:0] bu [8];
        logic [VW-1:0] bv [8];
        bit   ok;
        int   acc, p0, d0;
        bit   saw_ready, saw_busy;

        bus.in_valid = 1'b0;
        bus.in_u = '0;
        bus.in_v = '0;

        // Reset state
        repeat (3) tick();
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_in_ready", bus.in_ready, 1'b0);
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check1("rst_out_last", bus.out_last, 1'b0);
        check("rst_mul_u", RVW'(bus.mul_u), '0);
        check("rst_mul_v", RVW'(bus.mul_v), '0);
        Reset_n = 1'b1;
        tick();

        // Single job of three fixed pairs, latency per pair
        rdy_mode = 1;
        tick();
        d0 = n_done;
        pulse_start(3);
        for (int p = 0; p < 3; p++) begin
            send_pair({32'd2, 32'd3}, {32'd7, 32'd5}, {64'd14, 64'd15}, (p == 2), 20, ok);
            check1("t1_accept", ok, 1'b1);
            for (int k = 0; k < 20; k++) begin
                @(negedge Clock);
                if (bus.out_valid) break;
            end
            check_int("t1_latency", cyc - acc_cyc, MULT_LAT + 2);
            tick();
        end
        wait_done(20);
        check_int("t1_done_after_last", done_cyc - last_pop_cyc, 1);
        check_int("t1_done_count", n_done - d0, 1);

        // Zero-length job
        d0 = n_done;
        pulse_start(0);
        @(negedge Clock);
        check1("t2_done", done, 1'b1);
        check1("t2_busy", busy, 1'b0);
        saw_ready = 1'b0;
        saw_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            saw_ready |= bus.in_ready;
            saw_busy |= busy;
        end
        check1("t2_in_ready_never", saw_ready, 1'b0);
        check1("t2_busy_never", saw_busy, 1'b0);
        check_int("t2_done_count", n_done - d0, 1);
        tick();

        // Backpressure: only BUF_DEPTH pairs accepted while downstream stalls
        rdy_mode = 0;
        tick();
        p0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            bu[i] = rand_vec();
            bv[i] = rand_vec();
        end
        pulse_start(8);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            send_pair(bu[i], bv[i], ref_mult(bu[i], bv[i]), (i == 7), 20, ok);
            if (!ok) break;
            acc++;
        end
        check_int("t3_accepts_stalled", acc, BUF_DEPTH);
        rdy_mode = 1;
        for (int i = acc; i < 8; i++) begin
            send_pair(bu[i], bv[i], ref_mult(bu[i], bv[i]), (i == 7), 50, ok);
            check1("t3_accept_after", ok, 1'b1);
        end
        wait_done(50);
        check_int("t3_pops", n_pop - p0, 8);
        check_int("t3_queue_empty", expq.size(), 0);

        // Random handshakes, 100 pairs
        rdy_mode = 2;
        p0 = n_pop;
        pulse_start(100);
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            u = (i == 0) ? {VW{1'b1}} : rand_vec();
            v = (i == 0) ? {VW{1'b1}} : rand_vec();
            send_pair(u, v, ref_mult(u, v), (i == 99), 200, ok);
            check1("t4_accept", ok, 1'b1);
        end
        wait_done(2000);
        check_int("t4_pops", n_pop - p0, 100);
        check_int("t4_queue_empty", expq.size(), 0);

        // Reset with two results in flight and one buffered
        rdy_mode = 0;
        tick();
        pulse_start(3);
        for (int i = 0; i < 3; i++) begin
            u = rand_vec();
            v = rand_vec();
            send_pair(u, v, ref_mult(u, v), (i == 2), 20, ok);
            check1("t5_accept", ok, 1'b1);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (bus.out_valid) break;
        end
        check1("t5_pre_out_valid", bus.out_valid, 1'b1);
        check1("t5_pre_busy", busy, 1'b1);
        d0 = n_done;
        Reset_n = 1'b0;
        #1;
        check1("t5_rst_out_valid", bus.out_valid, 1'b0);
        check1("t5_rst_busy", busy, 1'b0);
        check1("t5_rst_in_ready", bus.in_ready, 1'b0);
        check1("t5_rst_out_last", bus.out_last, 1'b0);
        expq.delete();
        repeat (2) tick();
        Reset_n = 1'b1;
        repeat (6) tick();
        check_int("t5_no_done", n_done - d0, 0);
        rdy_mode = 1;
        p0 = n_pop;
        pulse_start(1);
        u = rand_vec();
        v = rand_vec();
        send_pair(u, v, ref_mult(u, v), 1'b1, 20, ok);
        check1("t5_new_accept", ok, 1'b1);
        wait_done(20);
        check_int("t5_new_pops", n_pop - p0, 1);

        // start during ISSUE is ignored
        d0 = n_done;
        p0 = n_pop;
        pulse_start(2);
        u = rand_vec();
        v = rand_vec();
        send_pair(u, v, ref_mult(u, v), 1'b0, 20, ok);
        pulse_start(5);
        u = rand_vec();
        v = rand_vec();
        send_pair(u, v, ref_mult(u, v), 1'b1, 20, ok);
        @(negedge Clock);
        check1("t6_in_ready_after", bus.in_ready, 1'b0);
        tick();
        wait_done(20);
        repeat (10) tick();
        check_int("t6_done_count", n_done - d0, 1);
        check_int("t6_pops", n_pop - p0, 2);
        check_int("t6_queue_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_mult_sequencer.md
Name: vec_mult_sequencer

Overview:
- Job-level controller that streams a batch of vector pairs through one external vectorMult instance (element-wise u*v, fixed pipeline latency, no stall input).
- Accepts pairs on a valid/ready input stream and tracks in-flight issues with a valid shift register.
- Captures results into a small output buffer and presents them on a valid/ready output stream.
- Uses credit-based issue so no result is ever lost under downstream backpressure.

Parameters:
- DIM, 10, elements per vector
- W_u, 32, bit-width of each u element
- W_v, 32, bit-width of each v element
- MULT_LAT, 2, cycles from mul_u/mul_v valid to the matching mul_result (vectorMult total latency)
- CNT_W, 16, width of the pair counter (max job = 2^CNT_W-1 pairs)
- BUF_DEPTH, 4, output buffer entries; must be >= MULT_LAT+1 (power of two)

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; launches a job when in IDLE
- num_pairs  in  CNT_W  pairs in the job, sampled on start
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse after the last result is accepted downstream
- in_valid  in  1  input pair valid
- in_ready  out  1  input pair accepted when in_valid & in_ready
- in_u  in  DIM*W_u  u vector
- in_v  in  DIM*W_v  v vector
- mul_u  out  DIM*W_u  to vectorMult u (registered)
- mul_v  out  DIM*W_v  to vectorMult v (registered)
- mul_result  in  DIM*(W_u+W_v)  from vectorMult result
- out_valid  out  1  buffered result valid
- out_ready  in  1  downstream accepts
- out_result  out  DIM*(W_u+W_v)  head-of-buffer result
- out_last  out  1  qualifies the final result of the job

Behaviour:
- Reset (async, Reset_n=0) forces:
  - state=IDLE; counters=0; valid pipe=0; buffer empty.
  - busy, done, in_ready, out_valid, out_last = 0; mul_u, mul_v = 0.
- FSM states:
  - IDLE: start with num_pairs==0 -> done pulses next cycle, stay IDLE. start with num_pairs>0 -> ISSUE, latch num_pairs into issue_left and drain_left. start while not IDLE is ignored.
  - ISSUE: in_ready = (issue_left!=0) & (credits>0). credits = BUF_DEPTH - buf_count - inflight. A handshake registers in_u/in_v into mul_u/mul_v, pushes 1 into the valid pipe, and decrements issue_left. issue_left reaching 0 -> DRAIN.
  - DRAIN: in_ready=0. When drain_left reaches 0 (last pop), done pulses and the FSM returns to IDLE.
- Valid pipe: MULT_LAT+1 stages (1 for the mul_u register, MULT_LAT for vectorMult). The tail asserted means mul_result is captured into the buffer that cycle. inflight = popcount(pipe).
- Buffer: FIFO; out_valid = !empty. A pop on out_valid & out_ready decrements drain_left. out_last = out_valid & (drain_left==1).
- Simultaneous push and pop: count unchanged, both pointers advance. A pop from a full buffer in the same cycle as a capture is legal. Overflow is impossible by credits; assert buf_count<=BUF_DEPTH.
- Issue-to-output latency: MULT_LAT+2 cycles from the in handshake to out_valid with an empty buffer. Throughput is one pair per cycle when out_ready is held high.
- mul_u/mul_v hold their last value when not issuing; vectorMult output is ignored unless the pipe tail is set.
- Reset mid-job: everything clears immediately; in-flight results are discarded; no done pulse.
- Width rules: counters are CNT_W bits with no wrap (num_pairs is bounded). Credits are $clog2(BUF_DEPTH)+1 bits.

Decomposition:
- Shared package vec_mult_pkg:
  - FSM state enum (IDLE, ISSUE, DRAIN).
  - Localparam RES_W = W_u+W_v.
  - Function clog2 helper.
- One sub-module: vm_result_fifo (parameterised width/depth; push, pop, count, full/empty).
- FSM, credits and valid pipe stay in the top.

Test Plan:
- Single job, num_pairs=3, DIM=2, out_ready=1; u={3,2}, v={5,7} per pair -> results {15,14} each, MULT_LAT+2 cycles after each accept; out_last on the 3rd; done one cycle after; busy low after.
- num_pairs=0 start -> done pulses next cycle; in_ready never high; busy stays 0.
- Backpressure: num_pairs=8, out_ready=0 -> in_ready drops after exactly BUF_DEPTH accepts (4). Then out_ready=1 -> all 8 results emerge in order, with no loss and no duplicate.
- Randomised in_valid/out_ready, 100 pairs of random operands including max values (all-ones 32-bit: product 0xFFFFFFFE00000001) -> scoreboard matches; buffer never overflows.
- Reset_n asserted while 2 results are in flight and 1 is buffered -> out_valid, busy, in_ready = 0 in the same cycle. A new job of 1 pair afterwards completes correctly.
- start pulsed during ISSUE -> ignored; job length unchanged; a single done pulse.
